// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the MEM stage: FSM states, output control
// bundle and the bubble helper that MEM/WB sees while an access is pending.
package mem_stage_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Control half of the registered output bundle; dout_sel routes RAM data
    // onto data_mem_dout only for loads.
    typedef struct packed {
        logic valid;
        logic mem_to_reg;
        logic reg_write;
        logic dout_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '0;

    // A bubble kills valid and RegWrite but leaves every other field as it was.
    function automatic ctrl_t make_bubble(input ctrl_t c);
        ctrl_t b;
        b           = c;
        b.valid     = 1'b0;
        b.reg_write = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/data_mem_sync.sv
// Single-port data memory: synchronous write, registered read, and
// write-through of the store data when a read and a write coincide.
module data_mem_sync
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_array [2**ADDR_W];
    logic [DATA_W-1:0] rdata_reg;

    // No reset on the array or read register so the tools can map it to block RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_array[addr] <= wdata;
                rdata_reg       <= wdata;
            end else begin
                rdata_reg       <= mem_array[addr];
            end
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 8-bit MIPS pipeline: wait-state FSM, request latch and the
// operand register feeding MEM/WB; stalls upstream while an access is pending.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic                  MemRead_in,
    input  logic                  MemWrite_in,
    input  logic                  MemtoReg_in,
    input  logic                  RegWrite_in,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic [DATA_W-1:0]     write_data,
    input  logic [REG_ADDR_W-1:0] rt_rd_addr_in,
    output logic                  stall,
    output logic                  valid_out,
    output logic                  MemtoReg,
    output logic                  RegWrite,
    output logic [DATA_W-1:0]     data_mem_dout,
    output logic [DATA_W-1:0]     alu_result,
    output logic [REG_ADDR_W-1:0] mem_wb_rt_rd_reg_address
);

    localparam int CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int CNT_INIT = (MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;

    logic                  req_read_reg;
    logic                  req_write_reg;
    logic                  req_mtr_reg;
    logic                  req_rw_reg;
    logic [DATA_W-1:0]     req_alu_reg;
    logic [DATA_W-1:0]     req_wdata_reg;
    logic [REG_ADDR_W-1:0] req_rd_reg;

    ctrl_t                 ctrl_reg;
    logic [DATA_W-1:0]     alu_reg;
    logic [REG_ADDR_W-1:0] rd_reg;

    logic memop;
    logic in_wait;
    logic complete;
    logic latch_req;
    logic stall_next;

    logic                  cur_read;
    logic                  cur_write;
    logic                  cur_mtr;
    logic                  cur_rw;
    logic [DATA_W-1:0]     cur_alu;
    logic [DATA_W-1:0]     cur_wdata;
    logic [REG_ADDR_W-1:0] cur_rd;

    logic                  mem_en;
    logic                  mem_we;
    logic [DATA_W-1:0]     mem_rdata;

    assign memop   = valid_in & (MemRead_in | MemWrite_in);
    assign in_wait = (state_reg == WAIT);

    // While waiting the latched request is authoritative; the ports are ignored.
    assign cur_read  = in_wait ? req_read_reg  : (valid_in & MemRead_in);
    assign cur_write = in_wait ? req_write_reg : (valid_in & MemWrite_in);
    assign cur_mtr   = in_wait ? req_mtr_reg   : MemtoReg_in;
    assign cur_rw    = in_wait ? req_rw_reg    : RegWrite_in;
    assign cur_alu   = in_wait ? req_alu_reg   : alu_result_in;
    assign cur_wdata = in_wait ? req_wdata_reg : write_data;
    assign cur_rd    = in_wait ? req_rd_reg    : rt_rd_addr_in;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        complete   = 1'b0;
        latch_req  = 1'b0;
        stall_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (memop && (MEM_LATENCY > 0)) begin
                    stall_next = 1'b1;
                    latch_req  = 1'b1;
                    state_next = WAIT;
                    cnt_next   = CNT_W'(CNT_INIT);
                end else if (valid_in) begin
                    complete   = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_reg != '0) begin
                    stall_next = 1'b1;
                    cnt_next   = cnt_reg - CNT_W'(1);
                end else begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign stall  = stall_next & ~rst;
    // Gating with rst keeps an aborted store out of the array.
    assign mem_en = complete & (cur_read | cur_write) & ~rst;
    assign mem_we = complete & cur_write & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            req_read_reg  <= 1'b0;
            req_write_reg <= 1'b0;
            req_mtr_reg   <= 1'b0;
            req_rw_reg    <= 1'b0;
            req_alu_reg   <= '0;
            req_wdata_reg <= '0;
            req_rd_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (latch_req) begin
                req_read_reg  <= MemRead_in;
                req_write_reg <= MemWrite_in;
                req_mtr_reg   <= MemtoReg_in;
                req_rw_reg    <= RegWrite_in;
                req_alu_reg   <= alu_result_in;
                req_wdata_reg <= write_data;
                req_rd_reg    <= rt_rd_addr_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_reg <= CTRL_RESET;
            alu_reg  <= '0;
            rd_reg   <= '0;
        end else if (complete) begin
            ctrl_reg <= '{valid: 1'b1, mem_to_reg: cur_mtr, reg_write: cur_rw, dout_sel: cur_read};
            alu_reg  <= cur_alu;
            rd_reg   <= cur_rd;
        end else begin
            ctrl_reg <= make_bubble(ctrl_reg);
        end
    end

    data_mem_sync #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_data_mem (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (cur_alu[ADDR_W-1:0]),
        .wdata (cur_wdata),
        .rdata (mem_rdata)
    );

    // RAM read data only reaches MEM/WB for loads; stores and ALU ops show zero.
    assign data_mem_dout            = ctrl_reg.dout_sel ? mem_rdata : '0;
    assign valid_out                = ctrl_reg.valid;
    assign MemtoReg                 = ctrl_reg.mem_to_reg;
    assign RegWrite                 = ctrl_reg.reg_write;
    assign alu_result               = alu_reg;
    assign mem_wb_rt_rd_reg_address = rd_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: four latencies side by side, directed cases plus random
// ops checked every cycle against a transaction-level model of the stage.
module tb_mem_stage;

    localparam int NI = 4;
    localparam int LAT [NI] = '{2, 0, 1, 3};

    typedef struct packed {
        logic       v;
        logic       mtr;
        logic       rw;
        logic [7:0] dout;
        logic [7:0] alu;
        logic [4:0] rd;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NI-1:0]      valid_in, rd_in, wr_in, mtr_in, rw_in;
    logic [NI-1:0][7:0] alu_in, wd_in;
    logic [NI-1:0][4:0] rda_in;
    logic [NI-1:0]      stall_o, valid_o, mtr_o, rw_o;
    logic [NI-1:0][7:0] dout_o, alu_o;
    logic [NI-1:0][4:0] rda_o;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        mem_stage #(
            .MEM_LATENCY (LAT[gi]),
            .ADDR_W      (8),
            .DATA_W      (8)
        ) u_dut (
            .clk                      (clk),
            .rst                      (rst),
            .valid_in                 (valid_in[gi]),
            .MemRead_in               (rd_in[gi]),
            .MemWrite_in              (wr_in[gi]),
            .MemtoReg_in              (mtr_in[gi]),
            .RegWrite_in              (rw_in[gi]),
            .alu_result_in            (alu_in[gi]),
            .write_data               (wd_in[gi]),
            .rt_rd_addr_in            (rda_in[gi]),
            .stall                    (stall_o[gi]),
            .valid_out                (valid_o[gi]),
            .MemtoReg                 (mtr_o[gi]),
            .RegWrite                 (rw_o[gi]),
            .data_mem_dout            (dout_o[gi]),
            .alu_result               (alu_o[gi]),
            .mem_wb_rt_rd_reg_address (rda_o[gi])
        );
    end

    // Model state: what each DUT must show this cycle, what the next edge will
    // produce, and the memory contents.
    out_t        exp_o [NI];
    out_t        pend  [NI];
    logic [NI-1:0] exp_stall;
    logic [7:0]  mdl_mem [NI][256];

    int   total = 0;
    int   bad   = 0;
    logic lit_on = 1'b0;
    int   lit_k  = 0;
    out_t lit_o;

    task automatic chk(input string nm, input int k, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s inst=%0d L=%0d got=%h want=%h t=%0t", nm, k, LAT[k], got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            chk("stall",    k, 8'(stall_o[k]), 8'(exp_stall[k]));
            chk("valid",    k, 8'(valid_o[k]), 8'(exp_o[k].v));
            chk("regwrite", k, 8'(rw_o[k]),    8'(exp_o[k].rw));
            chk("memtoreg", k, 8'(mtr_o[k]),   8'(exp_o[k].mtr));
            chk("dout",     k, dout_o[k],      exp_o[k].dout);
            chk("alu",      k, alu_o[k],       exp_o[k].alu);
            chk("rd",       k, 8'(rda_o[k]),   8'(exp_o[k].rd));
        end
        if (lit_on) begin
            chk("lit_valid", lit_k, 8'(valid_o[lit_k]), 8'(lit_o.v));
            chk("lit_dout",  lit_k, dout_o[lit_k],      lit_o.dout);
            chk("lit_alu",   lit_k, alu_o[lit_k],       lit_o.alu);
            chk("lit_rd",    lit_k, 8'(rda_o[lit_k]),   8'(lit_o.rd));
            chk("lit_mtr",   lit_k, 8'(mtr_o[lit_k]),   8'(lit_o.mtr));
            chk("lit_rw",    lit_k, 8'(rw_o[lit_k]),    8'(lit_o.rw));
        end
    end

    function automatic out_t bub(input out_t o);
        out_t b;
        b    = o;
        b.v  = 1'b0;
        b.rw = 1'b0;
        return b;
    endfunction

    // Start of a cycle: outputs become what the last edge produced; if nothing
    // else is scheduled, the coming edge produces a bubble. Idle inputs are junk.
    task automatic advance_all();
        for (int k = 0; k < NI; k++) begin
            exp_o[k]     = pend[k];
            pend[k]      = bub(pend[k]);
            exp_stall[k] = 1'b0;
            valid_in[k]  = 1'b0;
            rd_in[k]     = 1'($urandom);
            wr_in[k]     = 1'($urandom);
            mtr_in[k]    = 1'($urandom);
            rw_in[k]     = 1'($urandom);
            alu_in[k]    = 8'($urandom);
            wd_in[k]     = 8'($urandom);
            rda_in[k]    = 5'($urandom);
        end
    endtask

    task automatic do_op(input int i, input bit v, input bit r, input bit w, input bit m,
                         input bit g, input logic [7:0] a, input logic [7:0] d, input logic [4:0] rd);
        int   n;
        out_t res;
        n       = (v && (r || w)) ? LAT[i] : 0;
        res.v   = 1'b1;
        res.mtr = m;
        res.rw  = g;
        res.alu = a;
        res.rd  = rd;
        if (v && w)      res.dout = r ? d : 8'h00;
        else if (v && r) res.dout = mdl_mem[i][a];
        else             res.dout = 8'h00;
        for (int j = 0; j <= n; j++) begin
            @(posedge clk); #1;
            advance_all();
            if (j == 0) begin
                valid_in[i] = v;  rd_in[i]  = r;  wr_in[i] = w;  mtr_in[i] = m;
                rw_in[i]    = g;  alu_in[i] = a;  wd_in[i] = d;  rda_in[i] = rd;
            end else begin
                valid_in[i] = 1'($urandom);
            end
            exp_stall[i] = (j < n);
            if (j == n && v) begin
                pend[i] = res;
                if (w) mdl_mem[i][a] = d;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            exp_o[k]     = '0;
            pend[k]      = '0;
            exp_stall[k] = 1'b0;
            valid_in[k]  = 1'b0;
        end
        @(negedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
    endtask

    // Store whose wait is cut short by reset: only a zero-latency store lands.
    task automatic abort_store(input int i, input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        advance_all();
        valid_in[i] = 1'b1; rd_in[i] = 1'b0; wr_in[i] = 1'b1; mtr_in[i] = 1'b0;
        rw_in[i]    = 1'b0; alu_in[i] = a;   wd_in[i] = d;    rda_in[i] = 5'd0;
        exp_stall[i] = (LAT[i] > 0);
        if (LAT[i] == 0) mdl_mem[i][a] = d;
        @(posedge clk); #1;
        do_reset();
    endtask

    task automatic lit(input int i, input logic [7:0] dout, input logic [7:0] alu,
                       input logic [4:0] rd, input bit m, input bit g);
        @(posedge clk); #1;
        advance_all();
        lit_o  = '{v: 1'b1, mtr: m, rw: g, dout: dout, alu: alu, rd: rd};
        lit_k  = i;
        lit_on = 1'b1;
        @(negedge clk); #1;
        lit_on = 1'b0;
    endtask

    task automatic run_inst(input int i);
        logic [7:0] a;
        for (int k = 0; k < 8; k++) begin
            do_op(i, 1, 0, 1, 0, 0, 8'(k), 8'($urandom), 5'd0);
            do_op(i, 1, 0, 1, 0, 0, 8'(8'hF8 + k), 8'($urandom), 5'd0);
        end
        do_op(i, 1, 0, 1, 0, 0, 8'h20, 8'h42, 5'd0);
        do_op(i, 1, 0, 1, 0, 0, 8'h00, 8'h3E, 5'd0);
        // Plain ALU result passes straight through.
        do_op(i, 1, 0, 0, 0, 1, 8'h3C, 8'($urandom), 5'd7);
        lit(i, 8'h00, 8'h3C, 5'd7, 1'b0, 1'b1);
        do_op(i, 1, 0, 1, 0, 0, 8'h10, 8'hA5, 5'd0);
        do_op(i, 1, 1, 0, 1, 1, 8'h10, 8'h00, 5'd3);
        lit(i, 8'hA5, 8'h10, 5'd3, 1'b1, 1'b1);
        abort_store(i, 8'h20, 8'h5A);
        do_op(i, 1, 1, 0, 1, 1, 8'h20, 8'h00, 5'd4);
        lit(i, (LAT[i] > 0) ? 8'h42 : 8'h5A, 8'h20, 5'd4, 1'b1, 1'b1);
        do_op(i, 1, 0, 1, 0, 0, 8'hFF, 8'h11, 5'd0);
        do_op(i, 1, 1, 0, 1, 1, 8'hFF, 8'h00, 5'd1);
        lit(i, 8'h11, 8'hFF, 5'd1, 1'b1, 1'b1);
        do_op(i, 1, 1, 0, 1, 1, 8'h00, 8'h00, 5'd2);
        lit(i, 8'h3E, 8'h00, 5'd2, 1'b1, 1'b1);
        do_op(i, 1, 1, 1, 1, 1, 8'h05, 8'h77, 5'd9);
        lit(i, 8'h77, 8'h05, 5'd9, 1'b1, 1'b1);
        do_op(i, 1, 1, 0, 1, 0, 8'h05, 8'h00, 5'd10);
        lit(i, 8'h77, 8'h05, 5'd10, 1'b1, 1'b0);
        // Random mix, back to back, over addresses whose contents are known.
        for (int t = 0; t < 60; t++) begin
            a = {($urandom_range(1, 0) == 1) ? 5'h1F : 5'h00, 3'($urandom)};
            do_op(i, $urandom_range(99, 0) < 85, 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), a, 8'($urandom), 5'($urandom));
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            exp_o[k]     = '0;
            pend[k]      = '0;
            exp_stall[k] = 1'b0;
        end
        lit_o    = '0;
        valid_in = '0; rd_in = '0; wr_in = '0; mtr_in = '0; rw_in = '0;
        alu_in   = '0; wd_in = '0; rda_in = '0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < NI; i++) run_inst(i);
        repeat (3) begin
            @(posedge clk); #1;
            advance_all();
        end
        @(negedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
